ysyx_23060096_wbu: RTL and testbench



---
 rtl/ysyx_23060096_wbu_pkg.sv | 19 +
 rtl/ysyx_23060096_load_ext.sv | 23 ++
 rtl/ysyx_23060096_wbu.sv | 120 ++++++++++++
 tb/tb_ysyx_23060096_wbu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060096_wbu_pkg.sv
// Shared types for the write-back unit: load size encodings and the queue entry layout.
// The entry layout is fixed at 5-bit register addresses and 32-bit data.
package ysyx_23060096_wbu_pkg;

  localparam int unsigned WBU_ADDR_W = 5;
  localparam int unsigned WBU_DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } lsu_size_e;

  typedef struct packed {
    logic [WBU_ADDR_W-1:0] rd;
    logic [WBU_DATA_W-1:0] data;
  } wbu_entry_t;

endpackage

// File: rtl/ysyx_23060096_load_ext.sv
// Load-data formatter: byte/half extracted from the low bits and sign- or zero-extended.
// Word size and size code 11 pass the data through unchanged.
module ysyx_23060096_load_ext
  import ysyx_23060096_wbu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SIZE_B:  data_o = {{(DATA_WIDTH-8){signed_i & data_i[7]}}, data_i[7:0]};
      SIZE_H:  data_o = {{(DATA_WIDTH-16){signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: in-order queue of EXU/LSU results draining one register write per cycle.
// Optional bypass lookup ports are enabled by defining YSYX_23060096_WBU_BYPASS_EN.
module ysyx_23060096_wbu
  import ysyx_23060096_wbu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_signed,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef YSYX_23060096_WBU_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] byp_ra,
  input  logic [ADDR_WIDTH-1:0] byp_rb,
  output logic                  byp_hit_a,
  output logic                  byp_hit_b,
  output logic [DATA_WIDTH-1:0] byp_data_a,
  output logic [DATA_WIDTH-1:0] byp_data_b,
`endif
  output logic                  idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, exu_slot;
  logic [CW-1:0]         count_q, count_d, free;
  logic                  lsu_push, exu_push, pop;
  logic [DATA_WIDTH-1:0] lsu_fmt;
  wbu_entry_t            mem_q [DEPTH];
  wbu_entry_t            head;

  ysyx_23060096_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .data_i  (lsu_data),
    .size_i  (lsu_size),
    .signed_i(lsu_signed),
    .data_o  (lsu_fmt)
  );

  // Readiness uses registered free slots only; the pop this cycle is not credited.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    lsu_ready = (free >= CW'(1));
    exu_ready = (free >= (lsu_valid ? CW'(2) : CW'(1)));
    lsu_push  = lsu_valid & lsu_ready & (lsu_rd != '0);
    exu_push  = exu_valid & exu_ready & (exu_rd != '0);
    pop       = (count_q != '0);
    exu_slot  = wr_ptr_q + PW'(lsu_push);
    wr_ptr_d  = wr_ptr_q + PW'(lsu_push) + PW'(exu_push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(lsu_push) + CW'(exu_push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lsu_push) mem_q[wr_ptr_q] <= '{rd: lsu_rd, data: lsu_fmt};
    if (exu_push) mem_q[exu_slot] <= '{rd: exu_rd, data: exu_data};
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    rf_wen   = pop;
    rf_waddr = pop ? head.rd : '0;
    rf_wdata = pop ? head.data : '0;
    idle     = ~pop;
  end

`ifdef YSYX_23060096_WBU_BYPASS_EN
  logic [PW-1:0] byp_idx;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    byp_hit_a  = 1'b0;
    byp_hit_b  = 1'b0;
    byp_data_a = '0;
    byp_data_b = '0;
    byp_idx    = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((byp_ra != '0) && (mem_q[byp_idx].rd == byp_ra)) begin
          byp_hit_a  = 1'b1;
          byp_data_a = mem_q[byp_idx].data;
        end
        if ((byp_rb != '0) && (mem_q[byp_idx].rd == byp_rb)) begin
          byp_hit_b  = 1'b1;
          byp_data_b = mem_q[byp_idx].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Self-checking bench for ysyx_23060096_wbu: directed scenarios plus randomized traffic
// against a queue-based reference model. Bypass checks run when YSYX_23060096_WBU_BYPASS_EN is defined.
module tb_ysyx_23060096_wbu;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_valid = 1'b0, lsu_valid = 1'b0, lsu_signed = 1'b0;
  logic [4:0]  exu_rd = '0, lsu_rd = '0;
  logic [31:0] exu_data = '0, lsu_data = '0;
  logic [1:0]  lsu_size = '0;
  logic        exu_ready, lsu_ready, rf_wen, idle;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef YSYX_23060096_WBU_BYPASS_EN
  logic [4:0]  byp_ra = '0, byp_rb = '0;
  logic        byp_hit_a, byp_hit_b;
  logic [31:0] byp_data_a, byp_data_b;
`endif

  ysyx_23060096_wbu #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_size  (lsu_size),
    .lsu_signed(lsu_signed),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
`ifdef YSYX_23060096_WBU_BYPASS_EN
    .byp_ra    (byp_ra),
    .byp_rb    (byp_rb),
    .byp_hit_a (byp_hit_a),
    .byp_hit_b (byp_hit_b),
    .byp_data_a(byp_data_a),
    .byp_data_b(byp_data_b),
`endif
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        mq[$];
  int          total = 0;
  int          bad = 0;
  logic        obs_wen;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = d % 256;
        if (sg && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = d % 65536;
        if (sg && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // One cycle: check outputs against the model, drive new inputs, check readies, advance model.
  task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [1:0] lsz, input logic lsg,
                      input logic ev, input logic [4:0] erd, input logic [31:0] ed);
    bit   m_lrdy, m_erdy;
    exp_t e;
    @(negedge clk);
    obs_wen   = rf_wen;
    obs_waddr = rf_waddr;
    obs_wdata = rf_wdata;
    chk("rf_wen", {31'd0, rf_wen}, {31'd0, mq.size() != 0});
    chk("idle", {31'd0, idle}, {31'd0, mq.size() == 0});
    if (mq.size() != 0) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, mq[0].rd});
      chk("rf_wdata", rf_wdata, mq[0].data);
    end else begin
      chk("rf_waddr_empty", {27'd0, rf_waddr}, 32'd0);
      chk("rf_wdata_empty", rf_wdata, 32'd0);
    end
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; lsu_size = lsz; lsu_signed = lsg;
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    #1;
    m_lrdy = (mq.size() < DEPTH);
    m_erdy = (mq.size() + (lv ? 1 : 0) < DEPTH);
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_lrdy});
    chk("exu_ready", {31'd0, exu_ready}, {31'd0, m_erdy});
    if (mq.size() != 0) void'(mq.pop_front());
    if (lv && m_lrdy && lrd != 0) begin
      e.rd = lrd; e.data = fmt(ld, lsz, lsg); mq.push_back(e);
    end
    if (ev && m_erdy && erd != 0) begin
      e.rd = erd; e.data = ed; mq.push_back(e);
    end
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 32'd0, 2'd2, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) idle_step();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_exu_ready", {31'd0, exu_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle_step();

    // Single EXU write: visible exactly one cycle
    step(1'b0, 5'd0, 32'd0, 2'd2, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle_step();
    chk("exu_wen", {31'd0, obs_wen}, 32'd1);
    chk("exu_waddr", {27'd0, obs_waddr}, 32'd5);
    chk("exu_wdata", obs_wdata, 32'hDEADBEEF);
    idle_step();
    chk("exu_wen_after", {31'd0, obs_wen}, 32'd0);

    // Load formatting
    step(1'b1, 5'd10, 32'h000000F0, 2'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd11, 32'h000000F0, 2'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("ld_byte_s", obs_wdata, 32'hFFFFFFF0);
    step(1'b1, 5'd12, 32'h12348001, 2'd1, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("ld_byte_u", obs_wdata, 32'h000000F0);
    idle_step();
    chk("ld_half_s", obs_wdata, 32'hFFFF8001);
    chk("ld_half_s_addr", {27'd0, obs_waddr}, 32'd12);
    drain();

    // Dual accept and backpressure
    step(1'b1, 5'd1, 32'h100, 2'd2, 1'b0, 1'b1, 5'd2, 32'h200);
    chk("dual0_lrdy", {31'd0, lsu_ready}, 32'd1);
    chk("dual0_erdy", {31'd0, exu_ready}, 32'd1);
    step(1'b1, 5'd3, 32'h300, 2'd2, 1'b0, 1'b1, 5'd4, 32'h400);
    chk("dual1_erdy", {31'd0, exu_ready}, 32'd1);
    chk("seq0", {27'd0, obs_waddr}, 32'd1);
    step(1'b1, 5'd5, 32'h500, 2'd2, 1'b0, 1'b1, 5'd6, 32'h600);
    chk("dual2_lrdy", {31'd0, lsu_ready}, 32'd1);
    chk("dual2_erdy", {31'd0, exu_ready}, 32'd0);
    chk("seq1", {27'd0, obs_waddr}, 32'd2);
    idle_step();
    chk("seq2", {27'd0, obs_waddr}, 32'd3);
    idle_step();
    chk("seq3", {27'd0, obs_waddr}, 32'd4);
    idle_step();
    chk("seq4", {27'd0, obs_waddr}, 32'd5);
    chk("seq4_data", obs_wdata, 32'h500);
    idle_step();
    chk("seq_end_wen", {31'd0, obs_wen}, 32'd0);

    // x0 filter
    step(1'b1, 5'd3, 32'h33, 2'd2, 1'b0, 1'b1, 5'd0, 32'h77);
    chk("x0_lrdy", {31'd0, lsu_ready}, 32'd1);
    chk("x0_erdy", {31'd0, exu_ready}, 32'd1);
    idle_step();
    chk("x0_waddr", {27'd0, obs_waddr}, 32'd3);
    idle_step();
    chk("x0_single", {31'd0, obs_wen}, 32'd0);

`ifdef YSYX_23060096_WBU_BYPASS_EN
    byp_ra = 5'd7;
    byp_rb = 5'd0;
    step(1'b1, 5'd7, 32'h1, 2'd2, 1'b0, 1'b1, 5'd7, 32'h2);
    @(posedge clk);
    #1;
    chk("byp_hit_a", {31'd0, byp_hit_a}, 32'd1);
    chk("byp_data_a", byp_data_a, 32'h2);
    chk("byp_hit_b", {31'd0, byp_hit_b}, 32'd0);
    chk("byp_data_b", byp_data_b, 32'd0);
    drain();
`endif

    // Reset mid-drain with three entries queued
    step(1'b1, 5'd20, 32'hA0, 2'd2, 1'b0, 1'b1, 5'd21, 32'hA1);
    step(1'b1, 5'd22, 32'hA2, 2'd2, 1'b0, 1'b1, 5'd23, 32'hA3);
    @(posedge clk);
    #2;
    lsu_valid = 1'b0;
    exu_valid = 1'b0;
    chk("pre_rst_wen", {31'd0, rf_wen}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("mid_rst_idle", {31'd0, idle}, 32'd1);
    chk("mid_rst_lrdy", {31'd0, lsu_ready}, 32'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_step();
      chk("post_rst_wen", {31'd0, obs_wen}, 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic        lv, ev, lsg;
      logic [4:0]  lrd, erd;
      logic [1:0]  lsz;
      lv  = ($urandom_range(0, 3) != 0);
      ev  = ($urandom_range(0, 3) != 0);
      lrd = 5'($urandom_range(0, 31));
      erd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) lrd = 5'd0;
      if ($urandom_range(0, 7) == 0) erd = 5'd0;
      lsz = 2'($urandom_range(0, 3));
      lsg = 1'($urandom_range(0, 1));
      step(lv, lrd, $urandom, lsz, lsg, ev, erd, $urandom);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
